// File: rtl/mm_pkg.sv
// Shared types and constants for the modular-multiplier arbitration slice.
package mm_pkg;

    localparam int NUM_ELEMENTS = 17;
    localparam int BIT_LEN      = 17;
    localparam int WORD_LEN     = 16;

    // One redundant-form operand or result: NUM_ELEMENTS limbs of BIT_LEN bits.
    typedef logic [BIT_LEN-1:0] mm_vec_t [NUM_ELEMENTS];

    // SM2 prime; final reduction against it is left to the consumer of MM.
    localparam logic [255:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mm_state_t;

    // Flatten a limb array into one packed vector, limb 0 in the low bits.
    function automatic logic [NUM_ELEMENTS*BIT_LEN-1:0] mm_pack(input mm_vec_t v);
        logic [NUM_ELEMENTS*BIT_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            r[i*BIT_LEN +: BIT_LEN] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic          taken;
    logic [PW-1:0] idx;

    // Walk the requesters from ptr upward; the first asserted one wins.
    always_comb begin
        grant = '0;
        taken = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx        = PW'((int'(ptr) + k) % NUM_REQ);
            grant[idx] = req[idx] & ~taken;
            taken      = taken | req[idx];
        end
    end

endmodule

// File: rtl/mm_arbiter.sv
// Shares one modular-multiplier datapath between NUM_REQ requesters.
// One operation is in flight at a time: grant, settle for MUL_LAT cycles,
// capture MM, then hold the result until the owner accepts it.
module mm_arbiter
    import mm_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MUL_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  mm_vec_t            req_a [NUM_REQ],
    input  mm_vec_t            req_b [NUM_REQ],
    output logic [NUM_REQ-1:0] resp_valid,
    input  logic [NUM_REQ-1:0] resp_ready,
    output mm_vec_t            resp_mm,
    output mm_vec_t            mm_a,
    output mm_vec_t            mm_b,
    input  mm_vec_t            mm_result,
    output logic               busy
);

    localparam int         PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] CNT_INIT = 2'(MUL_LAT - 1);

    if ((NUM_REQ < 2) || (NUM_REQ > 4)) begin : g_bad_num_req
        $error("mm_arbiter: NUM_REQ must be in 2..4");
    end
    if ((MUL_LAT < 1) || (MUL_LAT > 4)) begin : g_bad_mul_lat
        $error("mm_arbiter: MUL_LAT must be in 1..4");
    end

    mm_state_t          state_r;
    mm_state_t          state_nxt_s;
    logic [PW-1:0]      owner_r;
    logic [PW-1:0]      ptr_r;
    logic [PW-1:0]      ptr_nxt_s;
    logic [1:0]         cnt_r;
    mm_vec_t            mm_a_r;
    mm_vec_t            mm_b_r;
    mm_vec_t            resp_mm_r;
    logic [NUM_REQ-1:0] arb_req_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [PW-1:0]      grant_idx_s;

    // Requests only compete while the datapath is free.
    assign arb_req_s = req_valid & {NUM_REQ{state_r == IDLE}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .req   (arb_req_s),
        .ptr   (ptr_r),
        .grant (grant_s)
    );

    // Encode the one-hot grant and the pointer value that follows it.
    always_comb begin
        grant_idx_s = '0;
        for (int g = 0; g < NUM_REQ; g++) begin
            grant_idx_s = grant_idx_s | (PW'(g) & {PW{grant_s[g]}});
        end
        if (grant_idx_s == PW'(NUM_REQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_idx_s + PW'(1);
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt_s = state_r;
        req_ready   = '0;
        resp_valid  = '0;
        case (state_r)
            IDLE: begin
                req_ready = grant_s;
                if (|grant_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 2'd0) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                resp_valid[owner_r] = 1'b1;
                if (resp_ready[owner_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus operand, counter, pointer and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            owner_r   <= '0;
            ptr_r     <= '0;
            cnt_r     <= 2'd0;
            mm_a_r    <= '{default: '0};
            mm_b_r    <= '{default: '0};
            resp_mm_r <= '{default: '0};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (|grant_s) begin
                        mm_a_r  <= req_a[grant_idx_s];
                        mm_b_r  <= req_b[grant_idx_s];
                        owner_r <= grant_idx_s;
                        cnt_r   <= CNT_INIT;
                        ptr_r   <= ptr_nxt_s;
                    end
                end
                WAIT: begin
                    if (cnt_r == 2'd0) begin
                        resp_mm_r <= mm_result;
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                RESP: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= 2'd0;
                end
            endcase
        end
    end

    assign mm_a    = mm_a_r;
    assign mm_b    = mm_b_r;
    assign resp_mm = resp_mm_r;
    assign busy    = (state_r != IDLE);

endmodule
